// File: rtl/ahb_interconnect.sv
// AHB-Lite slave-side interconnect: registered data-phase select, AND-OR response mux,
// built-in default slave for decode errors and a wait-state watchdog for hung slaves.
module ahb_interconnect #(
  parameter int unsigned NS      = 8,
  parameter int unsigned DW      = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             HCLK,
  input  logic             reset,
  input  logic [NS:0]      HSELRegions,
  input  logic [1:0]       HTRANS,
  input  logic [NS-1:0]    HREADYOUTS,
  input  logic [NS-1:0]    HRESPS,
  input  logic [NS*DW-1:0] HRDATAS,
  output logic [NS-1:0]    HSELS,
  output logic             HREADY,
  output logic             HRESP,
  output logic [DW-1:0]    HRDATA,
  output logic [NS-1:0]    SlvAbort,
  output logic             TimeoutFlag,
  output logic             DecodeErrFlag,
  input  logic             FlagClr
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_ERR1   = 2'd1;
  localparam logic [1:0] ST_ERR2   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [NS-1:0] dsel;
  logic [NS-1:0] sel_slv;
  logic          sel_onehot;
  logic          dsel_none;
  logic          slave_ready;
  logic          slave_resp;
  logic          decode_err;
  logic          timeout_hit;
  logic [DW-1:0] rdata_mux;
  logic          unused_bits;

  assign unused_bits = ^{HSELRegions[0], HTRANS[0]};

  assign sel_slv     = HSELRegions[NS:1];
  assign HSELS       = sel_slv;
  assign sel_onehot  = (sel_slv != '0) && ((sel_slv & (sel_slv - NS'(1))) == '0);
  assign dsel_none   = (dsel == '0);
  assign slave_ready = |(HREADYOUTS & dsel);
  assign slave_resp  = |(HRESPS & dsel);

  // Read data is masked by the registered data-phase select only
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < int'(NS); i++) begin
      rdata_mux = rdata_mux | (HRDATAS[i*DW +: DW] & {DW{dsel[i]}});
    end
  end

  assign HRDATA = (state == ST_NORMAL) ? rdata_mux : '0;

  // Bus response and next state; decode errors are detected whenever an address phase is accepted
  always_comb begin
    state_next = state;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    decode_err = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (!dsel_none) begin
          HREADY = slave_ready;
          HRESP  = slave_resp;
        end
      end
      ST_ERR1: begin
        HREADY     = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HREADY     = 1'b1;
        HRESP      = 1'b1;
        state_next = ST_NORMAL;
      end
      default: state_next = ST_NORMAL;
    endcase
    decode_err = HREADY && HTRANS[1] && !sel_onehot;
    if (decode_err || timeout_hit) state_next = ST_ERR1;
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] wait_cnt;
      logic          waiting;

      assign waiting     = (state == ST_NORMAL) && !dsel_none && !slave_ready;
      assign timeout_hit = waiting && (wait_cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
          wait_cnt <= '0;
        end else if (HREADY || timeout_hit) begin
          wait_cnt <= '0;
        end else if (waiting) begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end else begin : g_nowdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      state         <= ST_NORMAL;
      dsel          <= '0;
      SlvAbort      <= '0;
      TimeoutFlag   <= 1'b0;
      DecodeErrFlag <= 1'b0;
    end else begin
      state <= state_next;
      if (HREADY) begin
        dsel <= (HTRANS[1] && sel_onehot) ? sel_slv : '0;
      end else if (timeout_hit) begin
        dsel <= '0;
      end
      SlvAbort <= timeout_hit ? dsel : '0;
      // A set in the same cycle wins over a clear
      if (decode_err) begin
        DecodeErrFlag <= 1'b1;
      end else if (FlagClr) begin
        DecodeErrFlag <= 1'b0;
      end
      if (timeout_hit) begin
        TimeoutFlag <= 1'b1;
      end else if (FlagClr) begin
        TimeoutFlag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed self-checking bench for ahb_interconnect (NS=8, DW=64, TIMEOUT=4).
module tb_ahb_interconnect;

  localparam int unsigned NS      = 8;
  localparam int unsigned DW      = 64;
  localparam int unsigned TIMEOUT = 4;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  localparam logic [63:0] D1 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D4 = 64'h0505_0505_0505_0505;

  logic             HCLK;
  logic             reset;
  logic [NS:0]      HSELRegions;
  logic [1:0]       HTRANS;
  logic [NS-1:0]    HREADYOUTS;
  logic [NS-1:0]    HRESPS;
  logic [NS*DW-1:0] HRDATAS;
  logic [NS-1:0]    HSELS;
  logic             HREADY;
  logic             HRESP;
  logic [DW-1:0]    HRDATA;
  logic [NS-1:0]    SlvAbort;
  logic             TimeoutFlag;
  logic             DecodeErrFlag;
  logic             FlagClr;

  int checks = 0;
  int errors = 0;

  ahb_interconnect #(.NS(NS), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .HCLK         (HCLK),
    .reset        (reset),
    .HSELRegions  (HSELRegions),
    .HTRANS       (HTRANS),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .HRDATAS      (HRDATAS),
    .HSELS        (HSELS),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .HRDATA       (HRDATA),
    .SlvAbort     (SlvAbort),
    .TimeoutFlag  (TimeoutFlag),
    .DecodeErrFlag(DecodeErrFlag),
    .FlagClr      (FlagClr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    HSELRegions = 9'b000000001;
    HTRANS      = T_IDLE;
    FlagClr     = 1'b0;
  endtask

  task automatic chk_bus(input string name, input logic rdy, input logic rsp, input logic [DW-1:0] dat);
    checks++;
    if (HREADY !== rdy || HRESP !== rsp || HRDATA !== dat) begin
      errors++;
      $display("FAIL %s: HREADY=%b HRESP=%b HRDATA=%h, expected HREADY=%b HRESP=%b HRDATA=%h",
               name, HREADY, HRESP, HRDATA, rdy, rsp, dat);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    FlagClr    = 1'b0;
    HREADYOUTS = '1;
    HRESPS     = '0;
    for (int i = 0; i < int'(NS); i++) HRDATAS[i*DW +: DW] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    HRDATAS[2*DW +: DW] = D2;
    drive_idle();
    #12;
    chk_bus("reset_bus", 1'b1, 1'b0, 64'h0);
    checks++;
    if (SlvAbort !== 8'h00 || TimeoutFlag !== 1'b0 || DecodeErrFlag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: abort=%b tflag=%b dflag=%b, expected all 0", SlvAbort, TimeoutFlag, DecodeErrFlag);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    HSELRegions = 9'b000001000;
    HTRANS      = T_NONSEQ;
    #1;
    checks++;
    if (HSELS !== 8'b00000100) begin
      errors++;
      $display("FAIL hsels: HSELS=%b, expected 00000100", HSELS);
    end
    chk_bus("read_addr_phase", 1'b1, 1'b0, 64'h0);
    step();
    drive_idle();
    chk_bus("read_slave2", 1'b1, 1'b0, D2);
    step();
    chk_bus("read_done", 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_decode_err();
    HSELRegions = 9'b000000001;
    HTRANS      = T_NONSEQ;
    step();
    drive_idle();
    chk_bus("unmapped_err1", 1'b0, 1'b1, 64'h0);
    checks++;
    if (DecodeErrFlag !== 1'b1) begin
      errors++;
      $display("FAIL decode_flag: DecodeErrFlag=%b, expected 1", DecodeErrFlag);
    end
    step();
    chk_bus("unmapped_err2", 1'b1, 1'b1, 64'h0);
    // back-to-back decode error presented during ERR2
    HTRANS = T_NONSEQ;
    step();
    drive_idle();
    chk_bus("b2b_err1", 1'b0, 1'b1, 64'h0);
    step();
    chk_bus("b2b_err2", 1'b1, 1'b1, 64'h0);
    step();
    chk_bus("unmapped_okay", 1'b1, 1'b0, 64'h0);
    FlagClr = 1'b1;
    step();
    FlagClr = 1'b0;
    checks++;
    if (DecodeErrFlag !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear: DecodeErrFlag=%b, expected 0", DecodeErrFlag);
    end
    HTRANS = T_IDLE;
    step();
    chk_bus("idle_none_okay", 1'b1, 1'b0, 64'h0);
    checks++;
    if (DecodeErrFlag !== 1'b0) begin
      errors++;
      $display("FAIL idle_flag: DecodeErrFlag=%b, expected 0", DecodeErrFlag);
    end
  endtask

  task automatic test_multi_hot();
    HSELRegions = 9'b000010010;
    HTRANS      = T_NONSEQ;
    step();
    drive_idle();
    chk_bus("multihot_err1", 1'b0, 1'b1, 64'h0);
    step();
    chk_bus("multihot_err2", 1'b1, 1'b1, 64'h0);
    step();
    chk_bus("multihot_okay", 1'b1, 1'b0, 64'h0);
    FlagClr = 1'b1;
    step();
    FlagClr = 1'b0;
  endtask

  task automatic test_timeout();
    HREADYOUTS[5] = 1'b0;
    HSELRegions   = 9'b001000000;
    HTRANS        = T_NONSEQ;
    step();
    drive_idle();
    for (int w = 0; w < int'(TIMEOUT); w++) begin
      chk_bus($sformatf("timeout_wait%0d", w), 1'b0, 1'b0, 64'h0606_0606_0606_0606);
      checks++;
      if (SlvAbort !== 8'h00) begin
        errors++;
        $display("FAIL timeout_wait_abort%0d: SlvAbort=%b, expected 00000000", w, SlvAbort);
      end
      step();
    end
    chk_bus("timeout_err1", 1'b0, 1'b1, 64'h0);
    checks++;
    if (SlvAbort !== 8'b00100000 || TimeoutFlag !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: SlvAbort=%b TimeoutFlag=%b, expected 00100000 1", SlvAbort, TimeoutFlag);
    end
    HREADYOUTS[5] = 1'b1;
    #1;
    chk_bus("late_ready_err1", 1'b0, 1'b1, 64'h0);
    step();
    chk_bus("timeout_err2", 1'b1, 1'b1, 64'h0);
    checks++;
    if (SlvAbort !== 8'h00) begin
      errors++;
      $display("FAIL abort_pulse: SlvAbort=%b, expected 00000000", SlvAbort);
    end
    HRESPS[5] = 1'b1;
    step();
    chk_bus("timeout_after", 1'b1, 1'b0, 64'h0);
    HRESPS[5] = 1'b0;
    FlagClr   = 1'b1;
    step();
    FlagClr = 1'b0;
    checks++;
    if (TimeoutFlag !== 1'b0) begin
      errors++;
      $display("FAIL tflag_clear: TimeoutFlag=%b, expected 0", TimeoutFlag);
    end
  endtask

  task automatic test_back_to_back();
    HREADYOUTS[1] = 1'b0;
    HSELRegions   = 9'b000000100;
    HTRANS        = T_NONSEQ;
    step();
    HSELRegions = 9'b000100000;
    for (int w = 0; w < 3; w++) begin
      chk_bus($sformatf("b2b_wait%0d", w), 1'b0, 1'b0, D1);
      step();
    end
    HREADYOUTS[1] = 1'b1;
    #1;
    chk_bus("b2b_slave1_done", 1'b1, 1'b0, D1);
    step();
    drive_idle();
    chk_bus("b2b_slave4", 1'b1, 1'b0, D4);
    checks++;
    if (SlvAbort !== 8'h00 || TimeoutFlag !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_timeout: SlvAbort=%b TimeoutFlag=%b, expected 00000000 0", SlvAbort, TimeoutFlag);
    end
    step();
  endtask

  task automatic test_reset_in_err();
    HSELRegions = 9'b000000001;
    HTRANS      = T_NONSEQ;
    step();
    drive_idle();
    chk_bus("pre_reset_err1", 1'b0, 1'b1, 64'h0);
    reset = 1'b1;
    #1;
    chk_bus("reset_in_err1", 1'b1, 1'b0, 64'h0);
    checks++;
    if (DecodeErrFlag !== 1'b0 || SlvAbort !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_err1_flags: DecodeErrFlag=%b SlvAbort=%b, expected 0 00000000", DecodeErrFlag, SlvAbort);
    end
    #2;
    reset = 1'b0;
    step();
    chk_bus("after_reset", 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_flag_priority();
    HSELRegions = 9'b000000001;
    HTRANS      = T_NONSEQ;
    step();
    drive_idle();
    step();
    step();
    HTRANS  = T_NONSEQ;
    FlagClr = 1'b1;
    step();
    drive_idle();
    chk_bus("prio_err1", 1'b0, 1'b1, 64'h0);
    checks++;
    if (DecodeErrFlag !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: DecodeErrFlag=%b, expected 1", DecodeErrFlag);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_decode_err();
    test_multi_hot();
    test_timeout();
    test_back_to_back();
    test_reset_in_err();
    test_flag_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_interconnect.md
Name: ahb_interconnect

Overview:
- Parametrised AHB-Lite slave-side interconnect for the uncore: NS slave ports, registered data-phase select, and AND-OR read/response multiplexing.
- Adds behaviour the current uncore mux lacks:
  - built-in default slave giving a spec-compliant two-cycle ERROR response for unmapped or ambiguous (multi-hot) transfers;
  - wait-state watchdog that aborts a hung slave with an ERROR response.
- Sits between the address decoder (adrdecs) and the RAM/ROM/bridge/external slaves.

Parameters:
- NS, 8, number of slave ports.
- DW, 64, data width (AHBW).
- TIMEOUT, 256, maximum consecutive slave wait cycles before abort; 0 disables the watchdog.

Ports:
- HCLK  input  1  bus clock.
- reset  input  1  asynchronous, active-high reset.
- HSELRegions  input  NS+1  one-hot address-phase decode; bit 0 = no region, bits NS:1 = slaves 0..NS-1.
- HTRANS  input  2  master transfer type.
- HREADYOUTS  input  NS  per-slave HREADYOUT.
- HRESPS  input  NS  per-slave HRESP.
- HRDATAS  input  NS*DW  per-slave read data, slave i in bits [i*DW +: DW].
- HSELS  output  NS  slave selects, equal to HSELRegions[NS:1], combinational.
- HREADY  output  1  bus HREADY to master and all slaves.
- HRESP  output  1  bus HRESP.
- HRDATA  output  DW  bus read data.
- SlvAbort  output  NS  one-cycle pulse: slave i was timed out.
- TimeoutFlag  output  1  sticky; set on any timeout.
- DecodeErrFlag  output  1  sticky; set on any decode error.
- FlagClr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset values:
  - DSel (data-phase select) = none.
  - FSM = NORMAL, wait counter = 0.
  - HREADY = 1, HRESP = 0, HRDATA = 0.
  - SlvAbort = 0, both flags = 0.
- Address-phase accept:
  - Occurs on any cycle with HREADY = 1.
  - DSel <= HSELRegions[NS:1] if exactly one bit is set and HTRANS[1] = 1; otherwise DSel <= none.
  - DSel holds while HREADY = 0.
- Decode error:
  - Condition: an accepted transfer with HTRANS[1] = 1 and HSELRegions[NS:1] zero or multi-hot.
  - Next cycle enters ERR1; DecodeErrFlag is set.
- IDLE/BUSY transfers to no region: zero-wait OKAY (HREADY = 1, HRESP = 0).
- FSM states:
  - NORMAL:
    - If DSel = slave i: HREADY = HREADYOUTS[i], HRESP = HRESPS[i], HRDATA = slave i's data.
    - If DSel = none: HREADY = 1, HRESP = 0, HRDATA = 0.
  - ERR1: HREADY = 0, HRESP = 1, HRDATA = 0. Always goes to ERR2.
  - ERR2: HREADY = 1, HRESP = 1, HRDATA = 0. Always goes to NORMAL.
    - The address phase presented in ERR2 is accepted normally, including a back-to-back decode error, which goes to ERR1 again.
- Slave error responses pass through unmodified in NORMAL; the slave owns its own two-cycle sequence.
- Watchdog (TIMEOUT > 0):
  - Counter width is $clog2(TIMEOUT+1).
  - Increments each NORMAL cycle with DSel = slave i and HREADYOUTS[i] = 0; clears whenever HREADY = 1.
  - On the cycle where counter = TIMEOUT-1 and the slave is still not ready:
    - next state = ERR1;
    - SlvAbort[i] pulses in the ERR1 cycle;
    - TimeoutFlag is set;
    - DSel <= none, so later slave HREADYOUT/HRESP are ignored.
  - The master therefore sees exactly TIMEOUT wait cycles, then ERR1 and ERR2.
- Flag update on the same cycle: a set has priority over FlagClr.
- TIMEOUT = 0: no counter logic; slave waits are unbounded.
- Reset asserted mid-transfer: immediate return to reset values, including mid-ERR1/ERR2 and mid-wait.
- HRDATA is an AND-OR mux masked by the registered DSel only, never by the address-phase select.

Test Plan:
- Single read to slave 2 (HSELRegions = 0b000001000, HTRANS = NONSEQ, slave 2 zero-wait, data 0xDEADBEEF_01234567) -> next cycle HRDATA = 0xDEADBEEF_01234567, HREADY = 1, HRESP = 0; other slaves' data is masked.
- NONSEQ to unmapped address (HSELRegions = 0b1) -> ERR1 (HREADY = 0, HRESP = 1), then ERR2 (HREADY = 1, HRESP = 1), then OKAY; DecodeErrFlag = 1. Repeat with IDLE -> zero-wait OKAY, flag unchanged.
- Multi-hot decode (slaves 0 and 3) -> same two-cycle ERROR; HRDATA = 0 throughout.
- TIMEOUT = 4, slave 5 holds HREADYOUT = 0 -> 4 wait cycles, ERR1 with SlvAbort = 0b00100000, then ERR2; TimeoutFlag = 1. A later HREADYOUTS[5] = 1 has no effect on HREADY.
- Slave 1 three-wait then OKAY, followed back-to-back by a NONSEQ to slave 4 -> DSel holds slave 1 for 3 cycles; the slave 4 address is accepted only when HREADY = 1; the counter never exceeds 3.
- Reset asserted during ERR1, and separately FlagClr asserted together with a new decode error -> outputs at reset values immediately; the flag remains 1 (set wins).
